// File: rtl/rts_pkg.sv
// Shared types and LFSR helpers for the random target sequencer.
package rts_pkg;

   typedef enum logic [2:0] {IDLE, SEED, DRAW, PRESENT, GAP} state_t;

   localparam int unsigned BOX_NONE = 0;

   // Maximal-length tap masks (bit n-1 set for tap n), widths 3..16.
   function automatic logic [15:0] lfsr_taps(input int unsigned width);
      logic [15:0] t;
      case (width)
         3:       t = 16'h0006;
         4:       t = 16'h000C;
         5:       t = 16'h0014;
         6:       t = 16'h0030;
         7:       t = 16'h0060;
         8:       t = 16'h00B8;
         9:       t = 16'h0110;
         10:      t = 16'h0240;
         11:      t = 16'h0500;
         12:      t = 16'h0829;
         13:      t = 16'h100D;
         14:      t = 16'h2015;
         15:      t = 16'h6000;
         16:      t = 16'hD008;
         default: t = 16'h0000;
      endcase
      return t;
   endfunction

   // One Fibonacci step: shift left, XNOR of the taps enters at bit 0.
   function automatic logic [15:0] lfsr_next(input logic [15:0] cur, input int unsigned width);
      logic [16:0] mask;
      logic        fb;
      mask = (17'd1 << width) - 17'd1;
      fb   = ~^(cur & lfsr_taps(width));
      return {cur[14:0], fb} & mask[15:0];
   endfunction

endpackage

// File: rtl/random_target_sequencer_lfsr.sv
// Loadable W-bit XNOR LFSR; a zero load is replaced by 1.
module lfsr_n
   import rts_pkg::*;
#(
   parameter int unsigned W = 8
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         step,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= W'(1);
      else if (load)
         q <= (load_val == '0) ? W'(1) : load_val;
      else if (step)
         q <= W'(lfsr_next(16'(q), W));
   end

endmodule

// File: rtl/random_target_sequencer.sv
// Round sequencer: seeds, draws a non-repeating random box, presents it,
// then reports hit or miss and waits out the gap before the next draw.
module random_target_sequencer
   import rts_pkg::*;
#(
   parameter int unsigned LFSR_W      = 8,
   parameter int unsigned NUM_BOXES   = 5,
   parameter int unsigned BOX_W       = 3,
   parameter int unsigned BOX_BASE    = 1,
   parameter int unsigned PRESENT_CYC = 50000000,
   parameter int unsigned GAP_CYC     = 12500000,
   parameter int unsigned NO_REPEAT   = 1,
   parameter int unsigned MAX_TRIES   = 16
)(
   input  logic             CLOCK_50,
   input  logic             reset_signal,
   input  logic             start,
   input  logic             hit,
   output logic [BOX_W-1:0] target_box,
   output logic             target_valid,
   output logic             hit_ok,
   output logic             miss,
   output logic [7:0]       round_cnt
);

   localparam int unsigned PRES_W = (PRESENT_CYC > 1) ? $clog2(PRESENT_CYC) : 1;
   localparam int unsigned GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int unsigned TMR_W  = (PRES_W > GAP_W) ? PRES_W : GAP_W;
   localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);

   localparam logic [TMR_W-1:0] PRES_LAST = TMR_W'(PRESENT_CYC - 1);
   localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYC - 1);
   localparam logic [TRY_W-1:0] TRY_LAST  = TRY_W'(MAX_TRIES);
   localparam logic [BOX_W:0]   NUM_B     = (BOX_W+1)'(NUM_BOXES);
   localparam logic [BOX_W-1:0] LAST_IDX  = BOX_W'(NUM_BOXES - 1);
   localparam logic [BOX_W-1:0] BASE      = BOX_W'(BOX_BASE);

   logic [1:0]        rst_pipe;
   logic              rst;
   state_t            state, state_d;
   logic              start_q;
   logic [LFSR_W-1:0] free_cnt;
   logic [LFSR_W-1:0] lfsr_q;
   logic              lfsr_load, lfsr_step;
   logic [TMR_W-1:0]  timer, timer_d;
   logic [TRY_W-1:0]  tries, tries_d;
   logic [BOX_W-1:0]  prev_idx, prev_idx_d;
   logic              prev_vld, prev_vld_d;
   logic [BOX_W-1:0]  cand_raw, cand;
   logic              fallback, accept;
   logic [BOX_W-1:0]  box_d;
   logic              valid_d, hit_ok_d, miss_d;
   logic [7:0]        round_d;

   // Reset asserts asynchronously and releases two clocks later.
   always_ff @(posedge CLOCK_50 or posedge reset_signal) begin
      if (reset_signal) rst_pipe <= 2'b11;
      else              rst_pipe <= {rst_pipe[0], 1'b0};
   end
   assign rst = rst_pipe[1];

   lfsr_n #(.W(LFSR_W)) u_lfsr (
      .clk      (CLOCK_50),
      .rst      (rst),
      .load     (lfsr_load),
      .load_val (free_cnt),
      .step     (lfsr_step),
      .q        (lfsr_q)
   );

   // Candidate is taken from the value the LFSR steps to this cycle.
   assign cand_raw = BOX_W'(lfsr_next(16'(lfsr_q), LFSR_W));

   always_comb begin
      fallback = (tries == TRY_LAST);
      cand     = cand_raw;
      if (fallback)
         cand = !prev_vld ? '0 : ((prev_idx == LAST_IDX) ? '0 : prev_idx + BOX_W'(1));
      accept = fallback ||
               (({1'b0, cand} < NUM_B) &&
                ((NO_REPEAT == 0) || !prev_vld || (cand != prev_idx)));
   end

   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (start && !start_q) state_d = SEED;
         SEED:    state_d = DRAW;
         DRAW:    if (accept) state_d = PRESENT;
         PRESENT: if (hit || (timer == PRES_LAST)) state_d = GAP;
         GAP:     if (timer == GAP_LAST) state_d = start ? DRAW : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      timer_d    = timer;
      tries_d    = tries;
      prev_idx_d = prev_idx;
      prev_vld_d = prev_vld;
      box_d      = target_box;
      valid_d    = target_valid;
      hit_ok_d   = 1'b0;
      miss_d     = 1'b0;
      round_d    = round_cnt;
      lfsr_load  = 1'b0;
      lfsr_step  = 1'b0;
      case (state)
         SEED: begin
            lfsr_load = 1'b1;
            tries_d   = '0;
         end
         DRAW: begin
            lfsr_step = !fallback;
            tries_d   = tries + TRY_W'(1);
            if (accept) begin
               prev_idx_d = cand;
               prev_vld_d = 1'b1;
               box_d      = cand + BASE;
               valid_d    = 1'b1;
               timer_d    = '0;
            end
         end
         PRESENT: begin
            timer_d = timer + TMR_W'(1);
            if (hit || (timer == PRES_LAST)) begin
               hit_ok_d = hit;
               miss_d   = !hit;
               round_d  = round_cnt + 8'd1;
               valid_d  = 1'b0;
               box_d    = BOX_W'(BOX_NONE);
               timer_d  = '0;
            end
         end
         GAP: begin
            timer_d = timer + TMR_W'(1);
            tries_d = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         start_q      <= 1'b0;
         free_cnt     <= '0;
         timer        <= '0;
         tries        <= '0;
         prev_idx     <= '0;
         prev_vld     <= 1'b0;
         target_box   <= BOX_W'(BOX_NONE);
         target_valid <= 1'b0;
         hit_ok       <= 1'b0;
         miss         <= 1'b0;
         round_cnt    <= 8'd0;
      end else begin
         start_q      <= start;
         free_cnt     <= free_cnt + LFSR_W'(1);
         timer        <= timer_d;
         tries        <= tries_d;
         prev_idx     <= prev_idx_d;
         prev_vld     <= prev_vld_d;
         target_box   <= box_d;
         target_valid <= valid_d;
         hit_ok       <= hit_ok_d;
         miss         <= miss_d;
         round_cnt    <= round_d;
      end
   end

endmodule

// File: tb/tb_random_target_sequencer.sv
// Directed bench: seed-zero draw sequence, 200 miss rounds, hit timing,
// two-box alternation with start dropped mid-round, and mid-round reset.
module tb_random_target_sequencer;

   logic       CLOCK_50 = 1'b0;
   logic       reset_signal, start_a, hit_a, start_b, hit_b;
   logic [2:0] box_a, box_b;
   logic       valid_a, valid_b, hit_ok_a, hit_ok_b, miss_a, miss_b;
   logic [7:0] rc_a, rc_b;

   int n_cmp = 0;
   int n_bad = 0;
   int miss_tot_a = 0;

   // Reference draw model (LFSR_W=8, taps 8,6,5,4, NUM_BOXES=5, MAX_TRIES=16)
   logic [7:0] m_lfsr;
   logic [2:0] m_prev;
   logic       m_prev_vld;
   logic [2:0] cur_box, prev_box;

   always #10 CLOCK_50 = ~CLOCK_50;

   random_target_sequencer #(
      .LFSR_W(8), .NUM_BOXES(5), .BOX_W(3), .BOX_BASE(1), .PRESENT_CYC(8),
      .GAP_CYC(4), .NO_REPEAT(1), .MAX_TRIES(16)
   ) dut_a (
      .CLOCK_50(CLOCK_50), .reset_signal(reset_signal), .start(start_a), .hit(hit_a),
      .target_box(box_a), .target_valid(valid_a), .hit_ok(hit_ok_a), .miss(miss_a),
      .round_cnt(rc_a)
   );

   random_target_sequencer #(
      .LFSR_W(8), .NUM_BOXES(2), .BOX_W(3), .BOX_BASE(1), .PRESENT_CYC(8),
      .GAP_CYC(4), .NO_REPEAT(1), .MAX_TRIES(16)
   ) dut_b (
      .CLOCK_50(CLOCK_50), .reset_signal(reset_signal), .start(start_b), .hit(hit_b),
      .target_box(box_b), .target_valid(valid_b), .hit_ok(hit_ok_b), .miss(miss_b),
      .round_cnt(rc_b)
   );

   always @(negedge CLOCK_50) if (miss_a === 1'b1) miss_tot_a++;

   task automatic tick;
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
   endtask

   task automatic model_draw(output logic [2:0] box, output int lat);
      logic [2:0] c;
      logic       fb;
      lat = 0;
      c   = 3'd0;
      for (int t = 1; t <= 16; t++) begin
         fb     = ~(m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]);
         m_lfsr = {m_lfsr[6:0], fb};
         c      = m_lfsr[2:0];
         if (c < 3'd5 && !(m_prev_vld && c == m_prev)) begin
            lat = t;
            break;
         end
      end
      if (lat == 0) begin
         lat = 17;
         c   = !m_prev_vld ? 3'd0 : ((m_prev == 3'd4) ? 3'd0 : m_prev + 3'd1);
      end
      m_prev     = c;
      m_prev_vld = 1'b1;
      box        = c + 3'd1;
   endtask

   task automatic test_reset;
      start_a = 0; hit_a = 0; start_b = 0; hit_b = 0;
      reset_signal = 1'b1;
      #1;
      n_cmp++; if (box_a !== 3'd0)   begin n_bad++; $display("FAIL reset_box got=%0d exp=0", box_a); end
      n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
      n_cmp++; if (hit_ok_a !== 1'b0) begin n_bad++; $display("FAIL reset_hit_ok got=%b exp=0", hit_ok_a); end
      n_cmp++; if (miss_a !== 1'b0)  begin n_bad++; $display("FAIL reset_miss got=%b exp=0", miss_a); end
      n_cmp++; if (rc_a !== 8'd0)    begin n_bad++; $display("FAIL reset_round_cnt got=%0d exp=0", rc_a); end
      repeat (3) tick;
      reset_signal = 1'b0;
   endtask

   // Start timed so SEED sees free counter 0; the LFSR must then hold 1.
   task automatic test_seed_zero;
      int lat;
      repeat (257) tick;
      start_a = 1'b1;
      m_lfsr = 8'd1; m_prev = 3'd0; m_prev_vld = 1'b0;
      model_draw(cur_box, lat);
      repeat (2) tick;
      n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL seed_draw_early got=%b exp=0", valid_a); end
      tick;
      n_cmp++; if (valid_a !== 1'b1) begin n_bad++; $display("FAIL seed_first_valid got=%b exp=1", valid_a); end
      n_cmp++; if (box_a !== 3'd4)   begin n_bad++; $display("FAIL seed_first_box got=%0d exp=4", box_a); end
   endtask

   task automatic test_rounds_no_hit;
      int hi, lo, lat;
      logic [2:0] nxt;
      prev_box = 3'd0;
      for (int r = 1; r <= 200; r++) begin
         n_cmp++; if (box_a !== cur_box) begin n_bad++; $display("FAIL round_box r=%0d got=%0d exp=%0d", r, box_a, cur_box); end
         n_cmp++; if (box_a < 3'd1 || box_a > 3'd5) begin n_bad++; $display("FAIL round_range r=%0d got=%0d exp=1..5", r, box_a); end
         if (r > 1) begin
            n_cmp++; if (box_a === prev_box) begin n_bad++; $display("FAIL round_repeat r=%0d got=%0d exp!=%0d", r, box_a, prev_box); end
         end
         prev_box = box_a;
         hi = 1;
         for (int k = 0; k < 30; k++) begin
            tick;
            if (valid_a !== 1'b1) break;
            hi++;
         end
         n_cmp++; if (hi != 8)          begin n_bad++; $display("FAIL round_present_len r=%0d got=%0d exp=8", r, hi); end
         n_cmp++; if (miss_a !== 1'b1)  begin n_bad++; $display("FAIL round_miss r=%0d got=%b exp=1", r, miss_a); end
         n_cmp++; if (rc_a !== 8'(r))   begin n_bad++; $display("FAIL round_cnt r=%0d got=%0d exp=%0d", r, rc_a, r); end
         model_draw(nxt, lat);
         lo = 1;
         for (int k = 0; k < 60; k++) begin
            tick;
            if (valid_a === 1'b1) break;
            lo++;
         end
         n_cmp++; if (lo != 4 + lat) begin n_bad++; $display("FAIL round_gap_draw r=%0d got=%0d exp=%0d", r, lo, 4 + lat); end
         cur_box = nxt;
      end
      n_cmp++; if (miss_tot_a != 200) begin n_bad++; $display("FAIL miss_total got=%0d exp=200", miss_tot_a); end
      n_cmp++; if (rc_a !== 8'd200)   begin n_bad++; $display("FAIL round_cnt_200 got=%0d exp=200", rc_a); end
   endtask

   task automatic test_hit_mid;
      int lo, lat;
      logic [2:0] nxt;
      n_cmp++; if (box_a !== cur_box) begin n_bad++; $display("FAIL hit_mid_box got=%0d exp=%0d", box_a, cur_box); end
      repeat (3) tick;
      hit_a = 1'b1;
      tick;
      hit_a = 1'b0;
      n_cmp++; if (hit_ok_a !== 1'b1) begin n_bad++; $display("FAIL hit_mid_pulse got=%b exp=1", hit_ok_a); end
      n_cmp++; if (valid_a !== 1'b0)  begin n_bad++; $display("FAIL hit_mid_valid got=%b exp=0", valid_a); end
      n_cmp++; if (box_a !== 3'd0)    begin n_bad++; $display("FAIL hit_mid_box_clr got=%0d exp=0", box_a); end
      n_cmp++; if (miss_a !== 1'b0)   begin n_bad++; $display("FAIL hit_mid_miss got=%b exp=0", miss_a); end
      n_cmp++; if (rc_a !== 8'd201)   begin n_bad++; $display("FAIL hit_mid_cnt got=%0d exp=201", rc_a); end
      model_draw(nxt, lat);
      tick;
      n_cmp++; if (hit_ok_a !== 1'b0) begin n_bad++; $display("FAIL hit_mid_width got=%b exp=0", hit_ok_a); end
      lo = 2;
      for (int k = 0; k < 60; k++) begin
         if (valid_a === 1'b1) break;
         tick;
         if (valid_a !== 1'b1) lo++;
      end
      n_cmp++; if (lo != 4 + lat) begin n_bad++; $display("FAIL hit_mid_gap got=%0d exp=%0d", lo, 4 + lat); end
      n_cmp++; if (miss_tot_a != 200) begin n_bad++; $display("FAIL hit_mid_no_miss got=%0d exp=200", miss_tot_a); end
      cur_box = nxt;
   endtask

   task automatic test_hit_last;
      n_cmp++; if (box_a !== cur_box) begin n_bad++; $display("FAIL hit_last_box got=%0d exp=%0d", box_a, cur_box); end
      repeat (7) tick;
      n_cmp++; if (valid_a !== 1'b1) begin n_bad++; $display("FAIL hit_last_still_valid got=%b exp=1", valid_a); end
      hit_a = 1'b1;
      tick;
      hit_a = 1'b0;
      n_cmp++; if (hit_ok_a !== 1'b1) begin n_bad++; $display("FAIL hit_last_pulse got=%b exp=1", hit_ok_a); end
      n_cmp++; if (miss_a !== 1'b0)   begin n_bad++; $display("FAIL hit_last_miss got=%b exp=0", miss_a); end
      n_cmp++; if (valid_a !== 1'b0)  begin n_bad++; $display("FAIL hit_last_valid got=%b exp=0", valid_a); end
      n_cmp++; if (rc_a !== 8'd202)   begin n_bad++; $display("FAIL hit_last_cnt got=%0d exp=202", rc_a); end
      tick;
      n_cmp++; if (miss_a !== 1'b0)   begin n_bad++; $display("FAIL hit_last_late_miss got=%b exp=0", miss_a); end
      n_cmp++; if (miss_tot_a != 200) begin n_bad++; $display("FAIL hit_last_miss_total got=%0d exp=200", miss_tot_a); end
   endtask

   task automatic test_two_boxes_stop;
      int hi, lo, seen;
      logic [2:0] pb;
      start_b = 1'b1;
      lo = 0;
      for (int k = 0; k < 40; k++) begin
         tick;
         if (valid_b === 1'b1) break;
         lo++;
      end
      n_cmp++; if (lo > 19) begin n_bad++; $display("FAIL two_first_draw got=%0d exp<=19", lo); end
      pb = 3'd0;
      for (int r = 1; r <= 6; r++) begin
         n_cmp++; if (box_b !== 3'd1 && box_b !== 3'd2) begin n_bad++; $display("FAIL two_range r=%0d got=%0d exp=1|2", r, box_b); end
         if (r > 1) begin
            n_cmp++; if (box_b === pb) begin n_bad++; $display("FAIL two_alternate r=%0d got=%0d exp!=%0d", r, box_b, pb); end
         end
         pb = box_b;
         hi = 1;
         for (int k = 0; k < 30; k++) begin
            if (r == 6 && hi == 4) start_b = 1'b0;
            tick;
            if (valid_b !== 1'b1) break;
            hi++;
         end
         n_cmp++; if (hi != 8)         begin n_bad++; $display("FAIL two_present_len r=%0d got=%0d exp=8", r, hi); end
         n_cmp++; if (miss_b !== 1'b1) begin n_bad++; $display("FAIL two_miss r=%0d got=%b exp=1", r, miss_b); end
         n_cmp++; if (rc_b !== 8'(r))  begin n_bad++; $display("FAIL two_cnt r=%0d got=%0d exp=%0d", r, rc_b, r); end
         if (r < 6) begin
            lo = 1;
            for (int k = 0; k < 60; k++) begin
               tick;
               if (valid_b === 1'b1) break;
               lo++;
            end
            n_cmp++; if (lo < 5 || lo > 21) begin n_bad++; $display("FAIL two_gap_draw r=%0d got=%0d exp=5..21", r, lo); end
         end
      end
      seen = 0;
      for (int k = 0; k < 60; k++) begin
         tick;
         if (valid_b !== 1'b0) seen++;
      end
      n_cmp++; if (seen != 0)       begin n_bad++; $display("FAIL two_idle_valid got=%0d exp=0", seen); end
      n_cmp++; if (rc_b !== 8'd6)   begin n_bad++; $display("FAIL two_idle_cnt got=%0d exp=6", rc_b); end
   endtask

   task automatic test_reset_mid_present;
      int w;
      w = 0;
      while (valid_a !== 1'b1 && w < 60) begin tick; w++; end
      n_cmp++; if (valid_a !== 1'b1) begin n_bad++; $display("FAIL rst_mid_reach got=%b exp=1", valid_a); end
      repeat (2) tick;
      #3 reset_signal = 1'b1;
      #1;
      n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid_async got=%b exp=0", valid_a); end
      n_cmp++; if (box_a !== 3'd0)   begin n_bad++; $display("FAIL rst_mid_box_async got=%0d exp=0", box_a); end
      @(posedge CLOCK_50);
      #1;
      n_cmp++; if (valid_a !== 1'b0)  begin n_bad++; $display("FAIL rst_mid_valid got=%b exp=0", valid_a); end
      n_cmp++; if (box_a !== 3'd0)    begin n_bad++; $display("FAIL rst_mid_box got=%0d exp=0", box_a); end
      n_cmp++; if (rc_a !== 8'd0)     begin n_bad++; $display("FAIL rst_mid_cnt got=%0d exp=0", rc_a); end
      n_cmp++; if (hit_ok_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_hit_ok got=%b exp=0", hit_ok_a); end
      n_cmp++; if (miss_a !== 1'b0)   begin n_bad++; $display("FAIL rst_mid_miss got=%b exp=0", miss_a); end
      @(negedge CLOCK_50);
      reset_signal = 1'b0;
      tick;
   endtask

   initial begin
      reset_signal = 1'b1; start_a = 0; hit_a = 0; start_b = 0; hit_b = 0;
      @(negedge CLOCK_50);
      test_reset;
      test_seed_zero;
      test_rounds_no_hit;
      test_hit_mid;
      test_hit_last;
      test_two_boxes_stop;
      test_reset_mid_present;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/random_target_sequencer.md
Name: random_target_sequencer

Overview:
- Parametrised successor to the 3-bit box-picking LFSR: it draws a random target box and holds it for one presentation window.
- It owns the timing of one "round": seed capture, draw, present, then hit or timeout, then a gap before the next draw.
- It feeds the VGA box renderer (target_box/target_valid) and the game scorer (hit_ok/miss pulses).
- All logic is in the CLOCK_50 domain.

Parameters:
- LFSR_W, 8, LFSR width; legal values 3..16; taps come from the shared package.
- NUM_BOXES, 5, number of selectable boxes (2..2**BOX_W).
- BOX_W, 3, width of the target_box output.
- BOX_BASE, 1, offset added to the drawn index to form the box code (box 0 is reserved for "none").
- PRESENT_CYC, 50000000, length of the presentation window in clocks (1 s).
- GAP_CYC, 12500000, blank time between rounds in clocks.
- NO_REPEAT, 1, 1 = a box is never drawn twice in a row.
- MAX_TRIES, 16, cap on rejection-sampling retries per draw.

Ports:
- CLOCK_50, in, 1, system clock.
- reset_signal, in, 1, asynchronous, active-high reset.
- start, in, 1, level; high = run rounds, low = finish the current round then idle.
- hit, in, 1, one-cycle pulse from the input handler meaning "player struck target_box".
- target_box, out, BOX_W, box code to display; 0 when none.
- target_valid, out, 1, high while a target is presented.
- hit_ok, out, 1, one-cycle pulse: target hit in time.
- miss, out, 1, one-cycle pulse: window expired without a hit.
- round_cnt, out, 8, completed rounds; wraps 255 -> 0.

Behaviour:
- Reset (async assert, sync release): state=IDLE, lfsr=1, free counter=0, prev_idx=invalid.
- Reset values of outputs: target_box=0, target_valid=0, hit_ok=0, miss=0, round_cnt=0.
- Reset mid-round aborts immediately; no pulse is emitted.
- Free-running LFSR_W-bit counter increments every clock, including during IDLE.
- FSM states: IDLE, SEED, DRAW, PRESENT, GAP.
- IDLE:
  - Outputs are quiet.
  - A rising edge of start (registered start_q detects it) moves to SEED.
  - A start already high when reset releases counts as an edge.
- SEED (1 cycle):
  - lfsr <= free counter value.
  - If that value is 0, lfsr <= 1, so the all-zero lock state is never loaded.
  - Next state is DRAW.
- DRAW (1 LFSR step per cycle):
  - candidate = lfsr[BOX_W-1:0], taken after the step.
  - Accept the candidate if candidate < NUM_BOXES and (NO_REPEAT==0 or candidate != prev_idx).
  - On accept: prev_idx <= candidate, target_box <= candidate + BOX_BASE, target_valid <= 1, timer <= 0, go to PRESENT.
  - If no accept after MAX_TRIES steps: candidate = (prev_idx+1) mod NUM_BOXES, or 0 if prev_idx is invalid. Accept that deterministically.
  - Draw latency is therefore 1..MAX_TRIES+1 cycles.
- PRESENT:
  - The timer counts cycles.
  - If hit is seen: hit_ok pulses for 1 cycle, round_cnt += 1, target_valid <= 0, target_box <= 0, go to GAP.
  - Otherwise, when timer == PRESENT_CYC-1: miss pulses for 1 cycle, round_cnt += 1, outputs cleared, go to GAP.
  - hit in the same cycle as expiry counts as a hit; miss is not pulsed.
  - hit outside PRESENT is ignored.
- GAP:
  - Runs for GAP_CYC cycles.
  - Then go to DRAW if start is high, else to IDLE.
  - The LFSR is not reseeded between rounds.
- LFSR: Fibonacci with XNOR feedback, shifted left, taps from the package.
- Counter and timer widths: $clog2 of each *_CYC, minimum 1.

Decomposition:
- Package rts_pkg contains:
  - function lfsr_taps(width) returning a maximal-length tap mask for widths 3..16;
  - state enum {IDLE, SEED, DRAW, PRESENT, GAP};
  - constant BOX_NONE = 0.
- One sub-module, lfsr_n:
  - parameter W; inputs clk, rst, load, load_val, step; output q;
  - loading 0 forces 1.
- FSM, timers and the rejection logic stay in random_target_sequencer.

Test Plan (sim settings PRESENT_CYC=8, GAP_CYC=4, LFSR_W=8, NUM_BOXES=5):
- Reset asserted mid-PRESENT -> next edge shows target_valid=0, target_box=0, round_cnt=0, no hit_ok/miss pulse.
- Start rising with no hit, run 200 rounds:
  - every target_box is in 1..5;
  - consecutive values are never equal;
  - miss pulses 200 times;
  - round_cnt = 200.
- hit pulsed 3 cycles into PRESENT -> hit_ok is 1 for exactly 1 cycle, target_valid drops on the same edge, GAP lasts 4 cycles.
- hit on the final PRESENT cycle -> hit_ok=1, miss=0.
- Free counter forced to 0 at SEED -> lfsr=1; draws proceed and no stall exceeds MAX_TRIES+1 cycles.
- NUM_BOXES=2, NO_REPEAT=1 -> target_box alternates 1,2,1,2 …; start dropped mid-round -> current round completes, then IDLE.
